// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : param_updown_counter
//  Purpose  : Prescaled up/down counter with programmable terminal value
//             (modulus), wrap or saturate boundary behaviour, synchronous
//             load, compare-match pulse and a sticky boundary-event flag.
//  Ports    :
//    clk        in   1      clock, rising edge
//    reset      in   1      asynchronous, active-high reset
//    en         in   1      count enable (gates prescaler and counting)
//    dir        in   1      0 = count up, 1 = count down
//    sat_mode   in   1      0 = wrap at boundary, 1 = saturate at boundary
//    load       in   1      synchronous load strobe (wins over a tick)
//    load_val   in   WIDTH  value to load, clamped to modulus
//    modulus    in   WIDTH  terminal value; count range is 0..modulus
//    prescale   in   PSC_W  count steps once per prescale+1 enabled cycles
//    cmp_val    in   WIDTH  compare value for cmp_hit
//    clr_ovf    in   1      clears ovf_sticky
//    count      out  WIDTH  current count (registered)
//    tc         out  1      terminal-count pulse, one cycle per boundary event
//    cmp_hit    out  1      pulse when count changes to cmp_val
//    ovf_sticky out  1      set by any boundary event, cleared by clr_ovf
//  Revision : 1.0  initial release
// ============================================================================
module param_updown_counter #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  input  logic [PSC_W-1:0] prescale,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             cmp_hit,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);
  localparam logic [PSC_W-1:0] PSC_ZERO = '0;

  logic [PSC_W-1:0] psc_cnt;
  logic [PSC_W-1:0] psc_next;
  logic [WIDTH-1:0] count_next;
  logic             tick;
  logic             boundary;
  logic             hit_next;

  // Next-state selection. Load has priority over a tick and ignores en;
  // a boundary event can only come from a tick, never from a load.
  always_comb begin
    tick       = en && (psc_cnt == prescale);
    count_next = count;
    psc_next   = psc_cnt;
    boundary   = 1'b0;

    if (load) begin
      count_next = (load_val > modulus) ? modulus : load_val;
      psc_next   = PSC_ZERO;
    end else if (tick) begin
      psc_next = PSC_ZERO;
      if (!dir) begin
        // A count above modulus (modulus lowered at runtime) is treated
        // as already past the terminal value.
        if (count < modulus) begin
          count_next = count + CNT_ONE;
        end else begin
          boundary   = 1'b1;
          count_next = sat_mode ? modulus : CNT_ZERO;
        end
      end else begin
        if (count != CNT_ZERO) begin
          count_next = count - CNT_ONE;
        end else begin
          boundary   = 1'b1;
          count_next = sat_mode ? CNT_ZERO : modulus;
        end
      end
    end else if (en) begin
      psc_next = psc_cnt + PSC_ONE;
    end

    // Only a real change of value may raise cmp_hit, so a saturated hold
    // sitting on cmp_val stays quiet.
    hit_next = (load || tick) && (count_next != count) && (count_next == cmp_val);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= CNT_ZERO;
      psc_cnt    <= PSC_ZERO;
      tc         <= 1'b0;
      cmp_hit    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      count      <= count_next;
      psc_cnt    <= psc_next;
      tc         <= boundary;
      cmp_hit    <= hit_next;
      // Set wins over a simultaneous clear.
      ovf_sticky <= boundary | (ovf_sticky & ~clr_ovf);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_updown_counter
//  Purpose  : Self-checking bench for param_updown_counter (WIDTH=8,
//             PSC_W=4): directed vectors with literal expectations plus an
//             arithmetic reference model compared on every falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, dir, sat_mode, load, clr_ovf;
  logic [7:0] load_val, modulus, cmp_val;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       tc, cmp_hit, ovf_sticky;

  int vectors     = 0;
  int miscompares = 0;

  param_updown_counter #(.WIDTH(8), .PSC_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .modulus(modulus), .prescale(prescale),
    .cmp_val(cmp_val), .clr_ovf(clr_ovf), .count(count), .tc(tc),
    .cmp_hit(cmp_hit), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) -------------
  int m_count = 0;
  int m_psc   = 0;
  bit m_tc    = 0;
  bit m_hit   = 0;
  bit m_ovf   = 0;

  function automatic bit m_tick();
    return en && (m_psc == int'(prescale));
  endfunction

  function automatic int m_target();
    int lv = int'(load_val);
    int md = int'(modulus);
    if (load) return (lv > md) ? md : lv;
    if (!m_tick()) return m_count;
    if (!dir) return (m_count < md) ? m_count + 1 : (sat_mode ? md : 0);
    return (m_count > 0) ? m_count - 1 : (sat_mode ? 0 : md);
  endfunction

  function automatic bit m_edge();
    if (load || !m_tick()) return 1'b0;
    return dir ? (m_count == 0) : (m_count >= int'(modulus));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count <= 0; m_psc <= 0; m_tc <= 0; m_hit <= 0; m_ovf <= 0;
    end else begin
      m_count <= m_target();
      m_psc   <= (load || m_tick()) ? 0 : (en ? m_psc + 1 : m_psc);
      m_tc    <= m_edge();
      m_hit   <= (load || m_tick()) && (m_target() != m_count)
                 && (m_target() == int'(cmp_val));
      m_ovf   <= m_edge() | (m_ovf & !clr_ovf);
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("model_count", count, m_count);
      chk("model_tc", tc, m_tc);
      chk("model_cmp_hit", cmp_hit, m_hit);
      chk("model_ovf", ovf_sticky, m_ovf);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp34 [12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
  int exp35 [4]  = '{1, 0, 0, 0};
  int tc35  [4]  = '{0, 0, 1, 1};
  int exp38 [4]  = '{0, 0, 0, 1};
  int hits;

  initial begin
    en = 0; dir = 0; sat_mode = 0; load = 0; clr_ovf = 0;
    load_val = 0; modulus = 9; cmp_val = 200; prescale = 0;
    reset = 0;
    #1 reset = 1;
    #2;
    chk("reset_count", count, 0);
    chk("reset_tc", tc, 0);
    chk("reset_cmp_hit", cmp_hit, 0);
    chk("reset_ovf", ovf_sticky, 0);
    step();
    reset = 0;
    en    = 1;

    // Up, wrap, modulus 9, prescale 0 for 12 cycles.
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("wrap_up_count", count, i % 10);
      chk("wrap_up_tc", tc, (i == 10) ? 1 : 0);
    end
    chk("wrap_up_ovf", ovf_sticky, 1);

    // Clear alone, then clear coincident with a boundary event.
    clr_ovf = 1;
    step();
    chk("clr_alone_ovf", ovf_sticky, 0);
    chk("clr_alone_count", count, 3);
    clr_ovf = 0; load = 1; load_val = 9;
    step();
    chk("load9_count", count, 9);
    chk("load9_tc", tc, 0);
    load = 0; clr_ovf = 1;
    step();
    chk("set_clr_ovf", ovf_sticky, 1);
    chk("set_clr_tc", tc, 1);
    chk("set_clr_count", count, 0);
    step();
    chk("clr_next_ovf", ovf_sticky, 0);
    clr_ovf = 0;

    // Load clamps to modulus, overrides the tick, no tc.
    modulus = 50; load_val = 200; load = 1;
    step();
    chk("clamp_count", count, 50);
    chk("clamp_tc", tc, 0);
    chk("clamp_ovf", ovf_sticky, 0);

    // Down, saturate from 2, cmp_val = 1.
    dir = 1; sat_mode = 1; cmp_val = 1; load_val = 2;
    step();
    chk("sat_load_count", count, 2);
    load = 0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      hits += int'(cmp_hit);
      chk("sat_down_count", count, exp35[i]);
      chk("sat_down_tc", tc, tc35[i]);
    end
    chk("sat_down_hits", hits, 1);

    // Down, wrap at 0 goes to modulus.
    sat_mode = 0; cmp_val = 200;
    step();
    chk("wrap_down_count", count, 50);
    chk("wrap_down_tc", tc, 1);

    // Runtime modulus reduction below the count.
    load = 1; load_val = 8; modulus = 9;
    step();
    load = 0; modulus = 3;
    step();
    chk("above_mod_down", count, 7);
    chk("above_mod_down_tc", tc, 0);
    dir = 0; sat_mode = 1;
    step();
    chk("above_mod_up_sat", count, 3);
    chk("above_mod_up_tc", tc, 1);
    step();
    chk("sat_hold_count", count, 3);
    chk("sat_hold_tc", tc, 1);

    // modulus = 0: every tick a boundary event, count stays 0.
    modulus = 0; sat_mode = 0;
    step();
    chk("mod0_count_a", count, 0);
    chk("mod0_tc_a", tc, 1);
    step();
    chk("mod0_count_b", count, 0);
    chk("mod0_tc_b", tc, 1);

    // Prescale 3 with an enable gap of 5 cycles.
    modulus = 9; prescale = 3; load = 1; load_val = 0;
    step();
    load = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("psc_run_count", count, exp34[i]);
    end
    en = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("psc_hold_count", count, 1);
      chk("psc_hold_tc", tc, 0);
    end
    en = 1;
    for (int i = 6; i < 12; i++) begin
      step();
      chk("psc_resume_count", count, exp34[i]);
    end

    // Async reset mid-count / mid-prescale.
    sat_mode = 1; modulus = 0;
    step();
    chk("pre_reset_ovf", ovf_sticky, 1);
    modulus = 9; load = 1; load_val = 7;
    step();
    load = 0;
    step();
    step();
    chk("pre_reset_count", count, 7);
    #3 reset = 1;
    #1;
    chk("async_count", count, 0);
    chk("async_tc", tc, 0);
    chk("async_cmp_hit", cmp_hit, 0);
    chk("async_ovf", ovf_sticky, 0);
    step();
    chk("held_reset_count", count, 0);
    #2 reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_reset_count", count, exp38[i]);
    end

    #10;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
